signed_sat_accumulator: RTL and testbench
=========================================

SIGNED_SAT_ACCUMULATOR -- requirements
Module: signed_sat_accumulator

Interface
- REQ-001: Parameter MAX_BEATS, default 8: maximum number of beats per packet; legal range 1..15.
- REQ-002: clk  input  1  rising-edge clock; all state updates occur on this edge.
- REQ-003: rst  input  1  synchronous, active-high reset.
- REQ-004: up_valid  input  1  upstream beat valid.
- REQ-005: up_ready  output  1  block accepts a beat this cycle.
- REQ-006: up_data  input  4  signed two's-complement sample.
- REQ-007: up_last  input  1  final beat of the packet; qualified by up_valid.
- REQ-008: down_valid  output  1  packet result valid.
- REQ-009: down_ready  input  1  downstream accepts the result.
- REQ-010: down_data  output  4  saturated signed packet sum.
- REQ-011: down_sat  output  1  sticky flag: at least one saturation occurred in this packet.
- REQ-012: down_count  output  4  number of beats in the packet (1..MAX_BEATS).

Function
- REQ-013: The block SHALL have two states: ACC (collecting beats) and HOLD (presenting the result).
- REQ-014: In ACC, up_ready SHALL be 1 and down_valid SHALL be 0; in HOLD, up_ready SHALL be 0 and down_valid SHALL be 1.
- REQ-015: A beat SHALL be accepted only when up_valid and up_ready are both 1 on a clock edge.
- REQ-016: On each accepted beat, acc SHALL become sat_add(acc, up_data), count SHALL increment by 1, and the packet sat flag SHALL be ORed with this step's overflow.
- REQ-017: sat_add SHALL be computed as a 4-bit wrap sum; overflow exists when both operands share a sign and the sum's sign differs.
- REQ-018: On positive overflow, sat_add SHALL return +7 (0111); on negative overflow, it SHALL return -8 (1000); otherwise it SHALL return the wrap sum.
- REQ-019: Saturation SHALL be applied at every step, not only to the final sum.
- REQ-020: The packet SHALL close on an accepted beat with up_last=1, or on the accepted beat that brings count to MAX_BEATS, whichever comes first.
- REQ-021: On close, the block SHALL register down_data, down_sat and down_count from the post-update values of that same beat and enter HOLD on the next cycle.
- REQ-022: On close, the block SHALL clear the internal acc, count and sat flag to 0.
- REQ-023: Latency from the closing beat edge to down_valid=1 SHALL be exactly one cycle.
- REQ-024: In HOLD, down_data, down_sat and down_count SHALL remain stable until down_valid and down_ready are both 1 on a clock edge.
- REQ-025: After that handshake edge, the block SHALL return to ACC, with up_ready=1 in the following cycle and no beat accepted during the handshake cycle.
- REQ-026: up_last=1 on the first beat SHALL produce a one-beat packet with down_count=1.
- REQ-027: up_data and up_last SHALL be ignored whenever no beat is accepted.
- REQ-028: In HOLD, down_ready=0 SHALL hold the state indefinitely with no data loss.

Reset
- REQ-029: On rst=1 at a clock edge, the block SHALL enter ACC and clear acc, count, sat, down_valid, down_data, down_sat and down_count to 0.
- REQ-030: Reset SHALL take priority over a beat or handshake occurring in the same cycle.
- REQ-031: A packet interrupted by reset SHALL be discarded, and the next accepted beat SHALL start a new packet from 0.

Verification
- REQ-032: Beats 3, 2, 1(last) -> down_data=6, down_sat=0, down_count=3, with down_valid one cycle after the last beat.
- REQ-033: Beats 5, 4(last) -> down_data=7, down_sat=1, down_count=2.
- REQ-034: Beats -8, -1, +3(last) -> step results -8, -8 (sat), -5; down_data=1011, down_sat=1, down_count=3.
- REQ-035: MAX_BEATS=8, eight beats of +1 with up_last=0 -> forced close on the 8th beat; down_data=7, down_sat=1, down_count=8.
- REQ-036: Result pending with down_ready=0 for 5 cycles -> down_valid=1, outputs stable and up_ready=0 throughout; after the handshake, up_ready=1 on the next cycle.
- REQ-037: rst pulse after 2 beats of +2 -> all outputs 0 the next cycle; then beat +1(last) -> down_data=1, down_count=1, down_sat=0.

Source files
------------

// File: rtl/signed_sat_accumulator.sv
// Packet accumulator: sums signed 4-bit beats with per-step saturation and
// presents the sum, a sticky saturation flag and the beat count per packet.
module signed_sat_accumulator #(
  parameter int MAX_BEATS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up_valid,
  output logic       up_ready,
  input  logic [3:0] up_data,
  input  logic       up_last,
  output logic       down_valid,
  input  logic       down_ready,
  output logic [3:0] down_data,
  output logic       down_sat,
  output logic [3:0] down_count
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_BEATS);

  typedef enum logic {ACC, HOLD} state_t;

  typedef struct packed {
    logic [3:0] value;
    logic       ovf;
  } sat_res_t;

  state_t     state, state_next;
  logic [3:0] acc;
  logic [3:0] count;
  logic       sat;

  sat_res_t   step;
  logic [3:0] count_inc;
  logic       sat_inc;
  logic       beat_fire;
  logic       close;
  logic       handshake;

  // Two's-complement wrap add, clamped to +7 / -8 when the signs of the
  // operands agree but the sign of the wrapped sum does not.
  function automatic sat_res_t sat_add(input logic [3:0] a, input logic [3:0] b);
    sat_res_t   r;
    logic [3:0] sum;
    sum     = a + b;
    r.ovf   = (a[3] == b[3]) && (sum[3] != a[3]);
    r.value = r.ovf ? (a[3] ? 4'b1000 : 4'b0111) : sum;
    return r;
  endfunction

  assign up_ready   = (state == ACC);
  assign down_valid = (state == HOLD);

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    step       = sat_add(acc, up_data);
    count_inc  = count + 4'd1;
    sat_inc    = sat | step.ovf;
    beat_fire  = up_valid & up_ready;
    close      = beat_fire & (up_last | (count_inc == MAX_CNT));
    handshake  = down_valid & down_ready;
    state_next = state;
    case (state)
      ACC:     if (close)     state_next = HOLD;
      HOLD:    if (handshake) state_next = ACC;
      default:                state_next = ACC;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ACC;
      acc        <= '0;
      count      <= '0;
      sat        <= 1'b0;
      down_data  <= '0;
      down_sat   <= 1'b0;
      down_count <= '0;
    end else begin
      state <= state_next;
      if (beat_fire) begin
        if (close) begin
          // Publish the post-update values of the closing beat, then start
          // the next packet from a clean accumulator.
          down_data  <= step.value;
          down_sat   <= sat_inc;
          down_count <= count_inc;
          acc        <= '0;
          count      <= '0;
          sat        <= 1'b0;
        end else begin
          acc   <= step.value;
          count <= count_inc;
          sat   <= sat_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_signed_sat_accumulator.sv
// Directed bench for signed_sat_accumulator: hand-computed packet results,
// hold/backpressure behaviour and reset priority.
module tb_signed_sat_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       up_valid;
  logic       up_ready;
  logic [3:0] up_data;
  logic       up_last;
  logic       down_valid;
  logic       down_ready;
  logic [3:0] down_data;
  logic       down_sat;
  logic [3:0] down_count;

  int compared   = 0;
  int mismatched = 0;

  signed_sat_accumulator #(.MAX_BEATS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .up_last    (up_last),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data),
    .down_sat   (down_sat),
    .down_count (down_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, input logic [3:0] data,
                              input logic sat, input logic [3:0] cnt);
    check({tag, ".valid"}, {3'b0, down_valid}, 4'd1);
    check({tag, ".ready"}, {3'b0, up_ready},   4'd0);
    check({tag, ".data"},  down_data,          data);
    check({tag, ".sat"},   {3'b0, down_sat},   {3'b0, sat});
    check({tag, ".count"}, down_count,         cnt);
  endtask

  // Called at a negedge; presents one beat and returns at the next negedge.
  task automatic beat(input logic [3:0] d, input logic last);
    up_valid = 1'b1;
    up_data  = d;
    up_last  = last;
    @(negedge clk);
    up_valid = 1'b0;
    up_data  = 4'b1010;
    up_last  = 1'b1;
  endtask

  // Completes the result handshake while offering a junk beat that must be ignored.
  task automatic handshake(input string tag);
    down_ready = 1'b1;
    up_valid   = 1'b1;
    up_data    = 4'd7;
    up_last    = 1'b1;
    @(negedge clk);
    down_ready = 1'b0;
    up_valid   = 1'b0;
    check({tag, ".hs_ready"}, {3'b0, up_ready},   4'd1);
    check({tag, ".hs_valid"}, {3'b0, down_valid}, 4'd0);
  endtask

  initial begin
    rst        = 1'b1;
    up_valid   = 1'b1;
    up_data    = 4'd7;
    up_last    = 1'b1;
    down_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    up_valid = 1'b0;

    check("rst.ready", {3'b0, up_ready},   4'd1);
    check("rst.valid", {3'b0, down_valid}, 4'd0);
    check("rst.data",  down_data,          4'd0);
    check("rst.sat",   {3'b0, down_sat},   4'd0);
    check("rst.count", down_count,         4'd0);

    // 3 + 2 + 1 = 6, result visible one cycle after the last beat
    beat(4'd3, 1'b0);
    check("p1.mid_valid", {3'b0, down_valid}, 4'd0);
    beat(4'd2, 1'b0);
    check("p1.mid_ready", {3'b0, up_ready}, 4'd1);
    beat(4'd1, 1'b1);
    check_result("p1", 4'd6, 1'b0, 4'd3);
    handshake("p1");

    // 5 + 4 saturates to +7
    beat(4'd5, 1'b0);
    beat(4'd4, 1'b1);
    check_result("p2", 4'd7, 1'b1, 4'd2);
    handshake("p2");

    // -8, -1 -> -8 (sat), +3 -> -5; flag stays sticky
    beat(4'b1000, 1'b0);
    beat(4'b1111, 1'b0);
    beat(4'd3, 1'b1);
    check_result("p3", 4'b1011, 1'b1, 4'd3);
    handshake("p3");

    // Eight +1 beats without last: forced close at MAX_BEATS, 7+1 saturates
    for (int i = 0; i < 7; i++) begin
      beat(4'd1, 1'b0);
      check("p4.open", {3'b0, down_valid}, 4'd0);
    end
    beat(4'd1, 1'b0);
    check_result("p4", 4'd7, 1'b1, 4'd8);
    handshake("p4");

    // 2 + -3 = -1, then backpressure for 5 cycles with junk upstream traffic
    beat(4'd2, 1'b0);
    beat(4'b1101, 1'b1);
    up_valid = 1'b1;
    up_data  = 4'd6;
    up_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_result("p5.hold", 4'b1111, 1'b0, 4'd2);
    end
    up_valid = 1'b0;
    handshake("p5");

    // Idle cycles with junk data: nothing accepted, one-beat packet follows
    up_data = 4'd5;
    up_last = 1'b1;
    repeat (3) @(negedge clk);
    check("idle.valid", {3'b0, down_valid}, 4'd0);
    beat(4'b1110, 1'b1);
    check_result("p6", 4'b1110, 1'b0, 4'd1);

    // Reset wins over a handshake in the same cycle
    down_ready = 1'b1;
    rst        = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    down_ready = 1'b0;
    check("rsths.valid", {3'b0, down_valid}, 4'd0);
    check("rsths.data",  down_data,          4'd0);
    check("rsths.count", down_count,         4'd0);

    // Reset mid-packet discards the partial sum
    beat(4'd2, 1'b0);
    beat(4'd2, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid.valid", {3'b0, down_valid}, 4'd0);
    check("rstmid.ready", {3'b0, up_ready},   4'd1);
    check("rstmid.data",  down_data,          4'd0);
    check("rstmid.sat",   {3'b0, down_sat},   4'd0);
    check("rstmid.count", down_count,         4'd0);
    beat(4'd1, 1'b1);
    check_result("p7", 4'd1, 1'b0, 4'd1);
    handshake("p7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
